// File: rtl/pkt_modport_if.sv
// Packet stream bundle: data beat with sop/eop framing, byte-empty count and flow tag.
interface pkt_modport_if #(
    parameter int unsigned D_WIDTH     = 64,
    parameter int unsigned EMPTY_WIDTH = 3,
    parameter int unsigned FLOW_W      = 8
);
    logic [D_WIDTH-1:0]     data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
    logic                   val;
    logic [FLOW_W-1:0]      flow_num;

    modport master (output data, sop, eop, empty, val, flow_num);
    modport slave  (input  data, sop, eop, empty, val, flow_num);
endinterface

// File: rtl/pkt_modport.sv
// Per-flow L1 rate monitor (wire bytes incl. 20-byte IFG/preamble) with 1-cycle stream pass-through.
// Optional synchronous counter clear enabled by defining MODPORT_CLR_EN.
module pkt_modport #(
    parameter int unsigned D_WIDTH     = 64,
    parameter int unsigned EMPTY_WIDTH = 3,
    parameter int unsigned FLOW_CNT    = 16,
    parameter int unsigned FLOW_W      = 8,
    parameter int unsigned CNT_W       = 64,
    parameter int unsigned TICK_W      = 48
) (
    input  logic               clk,
    input  logic               rst,
    pkt_modport_if.slave       in_if,
    pkt_modport_if.master      out_if,
    input  logic [FLOW_W-1:0]  rd_flow,
    output logic [CNT_W-1:0]   rd_bytes,
    output logic [CNT_W-1:0]   rd_pkts,
    output logic [TICK_W-1:0]  tick_cnt,
`ifdef MODPORT_CLR_EN
    input  logic               clr,
`endif
    output logic [31:0]        bad_flow_cnt
);

    localparam int unsigned BPW   = D_WIDTH / 8;
    localparam int unsigned ADD_W = ((CNT_W > 32) ? CNT_W : 32) + 1;
    localparam int unsigned IDX_W = (FLOW_CNT > 1) ? $clog2(FLOW_CNT) : 1;

    logic [CNT_W-1:0] bytes [FLOW_CNT];
    logic [CNT_W-1:0] pkts  [FLOW_CNT];

    logic             clr_i;
    logic [31:0]      empty_c;
    logic [31:0]      contrib;
    logic             flow_ok;
    logic             rd_ok;
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;

`ifdef MODPORT_CLR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    // Extra headroom bits catch any carry out of the counter width.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [31:0] inc);
        logic [ADD_W-1:0] s;
        s = ADD_W'(cnt) + ADD_W'(inc);
        return (|s[ADD_W-1:CNT_W]) ? '1 : s[CNT_W-1:0];
    endfunction

    always_comb begin
        empty_c = 32'(in_if.empty);
        if (empty_c > BPW)
            empty_c = BPW;
        contrib = in_if.eop ? (BPW - empty_c + 32'd20) : BPW;
        flow_ok = 32'(in_if.flow_num) < FLOW_CNT;
        rd_ok   = 32'(rd_flow) < FLOW_CNT;
        widx    = in_if.flow_num[IDX_W-1:0];
        ridx    = rd_flow[IDX_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_if.data     <= '0;
            out_if.sop      <= 1'b0;
            out_if.eop      <= 1'b0;
            out_if.empty    <= '0;
            out_if.val      <= 1'b0;
            out_if.flow_num <= '0;
        end else begin
            out_if.data     <= in_if.data;
            out_if.sop      <= in_if.sop;
            out_if.eop      <= in_if.eop;
            out_if.empty    <= in_if.empty;
            out_if.val      <= in_if.val;
            out_if.flow_num <= in_if.flow_num;
        end
    end

    // Readout samples the counters before this edge's update lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bytes <= '0;
            rd_pkts  <= '0;
        end else begin
            rd_bytes <= rd_ok ? bytes[ridx] : '0;
            rd_pkts  <= rd_ok ? pkts[ridx]  : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FLOW_CNT; i++) begin
                bytes[i] <= '0;
                pkts[i]  <= '0;
            end
            tick_cnt     <= '0;
            bad_flow_cnt <= '0;
        end else if (clr_i) begin
            for (int unsigned i = 0; i < FLOW_CNT; i++) begin
                bytes[i] <= '0;
                pkts[i]  <= '0;
            end
            tick_cnt     <= '0;
            bad_flow_cnt <= '0;
        end else begin
            if (tick_cnt != '1)
                tick_cnt <= tick_cnt + 1'b1;
            if (in_if.val) begin
                if (flow_ok) begin
                    bytes[widx] <= sat_add(bytes[widx], contrib);
                    if (in_if.eop)
                        pkts[widx] <= sat_add(pkts[widx], 32'd1);
                end else if (bad_flow_cnt != '1) begin
                    bad_flow_cnt <= bad_flow_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_modport.sv
// Bench for pkt_modport: directed table, randomized stream against a counting model, saturation.
module tb_pkt_modport;

    localparam int CNT_W    = 16;
    localparam longint CMAX = 65535;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_flow;
    logic [15:0] rd_bytes;
    logic [15:0] rd_pkts;
    logic [47:0] tick_cnt;
    logic [31:0] bad_flow_cnt;
`ifdef MODPORT_CLR_EN
    logic        clr;
`endif

    always #5 clk = ~clk;

    pkt_modport_if #(.D_WIDTH(64), .EMPTY_WIDTH(3), .FLOW_W(8)) in_if ();
    pkt_modport_if #(.D_WIDTH(64), .EMPTY_WIDTH(3), .FLOW_W(8)) out_if ();

    pkt_modport #(
        .D_WIDTH(64), .EMPTY_WIDTH(3), .FLOW_CNT(16), .FLOW_W(8), .CNT_W(CNT_W), .TICK_W(48)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_if(in_if.slave),
        .out_if(out_if.master),
        .rd_flow(rd_flow),
        .rd_bytes(rd_bytes),
        .rd_pkts(rd_pkts),
        .tick_cnt(tick_cnt),
`ifdef MODPORT_CLR_EN
        .clr(clr),
`endif
        .bad_flow_cnt(bad_flow_cnt)
    );

    longint m_bytes [16];
    longint m_pkts  [16];
    longint m_tick;
    longint m_bad;
    int nchk = 0;
    int npass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_bytes[i] = 0;
            m_pkts[i]  = 0;
        end
        m_tick = 0;
        m_bad  = 0;
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [2:0] emp,
                         input logic [7:0] f, input logic [7:0] rf);
        in_if.val = v; in_if.sop = s; in_if.eop = e; in_if.empty = emp;
        in_if.flow_num = f; rd_flow = rf;
        in_if.data = {$urandom, $urandom};
    endtask

    // One clock: predict from the inputs presented now, advance the model, check after the edge.
    task automatic step();
        logic [63:0] e_data;
        logic        e_sop, e_eop, e_val, c;
        logic [2:0]  e_emp;
        logic [7:0]  e_flow;
        longint      e_rb, e_rp, inc, emp;
        int          f;
        c = 1'b0;
`ifdef MODPORT_CLR_EN
        c = clr;
`endif
        if (rst) begin
            e_data = '0; e_sop = 0; e_eop = 0; e_val = 0; e_emp = '0; e_flow = '0;
            e_rb = 0; e_rp = 0;
            model_clear();
        end else begin
            e_data = in_if.data; e_sop = in_if.sop; e_eop = in_if.eop; e_val = in_if.val;
            e_emp = in_if.empty; e_flow = in_if.flow_num;
            e_rb = (rd_flow < 16) ? m_bytes[rd_flow] : 0;
            e_rp = (rd_flow < 16) ? m_pkts[rd_flow]  : 0;
            if (c) begin
                model_clear();
            end else begin
                m_tick++;
                f = int'(in_if.flow_num);
                if (in_if.val) begin
                    if (f < 16) begin
                        emp = (in_if.empty > 8) ? 8 : longint'(in_if.empty);
                        inc = in_if.eop ? (8 - emp + 20) : 8;
                        m_bytes[f] = (m_bytes[f] + inc > CMAX) ? CMAX : m_bytes[f] + inc;
                        if (in_if.eop) m_pkts[f] = (m_pkts[f] + 1 > CMAX) ? CMAX : m_pkts[f] + 1;
                    end else begin
                        m_bad = (m_bad == 64'hFFFFFFFF) ? m_bad : m_bad + 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_data", out_if.data, e_data);
        chk("out_sop", 64'(out_if.sop), 64'(e_sop));
        chk("out_eop", 64'(out_if.eop), 64'(e_eop));
        chk("out_val", 64'(out_if.val), 64'(e_val));
        chk("out_empty", 64'(out_if.empty), 64'(e_emp));
        chk("out_flow_num", 64'(out_if.flow_num), 64'(e_flow));
        chk("rd_bytes", 64'(rd_bytes), e_rb);
        chk("rd_pkts", 64'(rd_pkts), e_rp);
        chk("tick_cnt", 64'(tick_cnt), m_tick);
        chk("bad_flow_cnt", 64'(bad_flow_cnt), m_bad);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       val, sop, eop;
        logic [2:0] empty;
        logic [7:0] flow, rdf;
        logic [15:0] eb, ep;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
`ifdef MODPORT_CLR_EN
        clr = 1'b0;
`endif
        drive(0, 0, 0, 0, 0, 0);
        model_clear();
        #2;
        chk("reset_out_val", 64'(out_if.val), 64'd0);
        chk("reset_out_data", out_if.data, 64'd0);
        chk("reset_tick", 64'(tick_cnt), 64'd0);
        chk("reset_rd_bytes", 64'(rd_bytes), 64'd0);
        chk("reset_bad", 64'(bad_flow_cnt), 64'd0);
        do_reset();

        // 3-beat packet on flow 2, empty=4: 8 + 8 + 4 + 20 = 40 bytes
        tbl[0] = '{1, 1, 0, 0, 2,  2,  0, 0};
        tbl[1] = '{1, 0, 0, 0, 2,  2,  8, 0};
        tbl[2] = '{1, 0, 1, 4, 2,  2, 16, 0};
        tbl[3] = '{0, 0, 0, 0, 2,  2, 40, 1};
        tbl[4] = '{0, 0, 0, 0, 2,  3,  0, 0};
        tbl[5] = '{0, 0, 0, 0, 2, 20,  0, 0};
        tbl[6] = '{0, 0, 0, 0, 2,  2, 40, 1};
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].val, tbl[i].sop, tbl[i].eop, tbl[i].empty, tbl[i].flow, tbl[i].rdf);
            step();
            chk($sformatf("tbl%0d_rd_bytes", i), 64'(rd_bytes), 64'(tbl[i].eb));
            chk($sformatf("tbl%0d_rd_pkts", i), 64'(rd_pkts), 64'(tbl[i].ep));
        end

        // Out-of-range flow: three valid beats, one idle beat
        for (int i = 0; i < 4; i++) begin
            drive(i != 3, 1, 1, 0, 20, 2);
            step();
        end
        drive(0, 0, 0, 0, 0, 2);
        step();
        chk("bad_flow_count", 64'(bad_flow_cnt), 64'd3);
        chk("bad_flow_rd_bytes", 64'(rd_bytes), 64'd40);
        chk("bad_flow_rd_pkts", 64'(rd_pkts), 64'd1);

        // 100 single-beat packets on flow 5: 100 * 28 = 2800 bytes
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1, 1, 1, 0, 5, 5);
            step();
        end
        chk("rate_tick_100", 64'(tick_cnt), 64'd100);
        drive(0, 0, 0, 0, 0, 5);
        step();
        chk("rate_rd_bytes", 64'(rd_bytes), 64'd2800);
        chk("rate_rd_pkts", 64'(rd_pkts), 64'd100);

        // Randomized stream with an asynchronous reset in the middle
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                  8'($urandom_range(0, 19)), 8'($urandom_range(0, 18)));
            step();
            if (i == 200) begin
                drive(1, 0, 0, 0, 3, 3);
                #2;
                rst = 1'b1;
                #1;
                chk("async_rst_out_val", 64'(out_if.val), 64'd0);
                chk("async_rst_out_data", out_if.data, 64'd0);
                chk("async_rst_out_flow", 64'(out_if.flow_num), 64'd0);
                chk("async_rst_rd_bytes", 64'(rd_bytes), 64'd0);
                chk("async_rst_tick", 64'(tick_cnt), 64'd0);
                chk("async_rst_bad", 64'(bad_flow_cnt), 64'd0);
                step();
                rst = 1'b0;
            end
        end

        // Saturation: 2400 * 28 bytes overflows a 16-bit counter
        do_reset();
        for (int i = 0; i < 2400; i++) begin
            drive(1, 1, 1, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("sat_rd_bytes", 64'(rd_bytes), 64'hFFFF);
        chk("sat_rd_pkts", 64'(rd_pkts), 64'd2400);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("sat_hold_rd_bytes", 64'(rd_bytes), 64'hFFFF);

`ifdef MODPORT_CLR_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 0, 0, 0, 1, 1);
            step();
        end
        drive(1, 0, 1, 0, 1, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        step();
        chk("clr_tick_restart", 64'(tick_cnt), 64'd1);
        chk("clr_rd_bytes", 64'(rd_bytes), 64'd0);
        chk("clr_rd_pkts", 64'(rd_pkts), 64'd0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
